des_key_schedule: RTL
=====================

# des_key_schedule

Iterative DES key-schedule generator. Accepts a 64-bit key and emits the sixteen 48-bit round subkeys, one per handshake. Subkeys are in encrypt order (K1..K16) or decrypt order (K16..K1). It sits directly upstream of the round datapath, where each subkey is XORed with the expanded right half before the eight S-boxes.

## Interface
- No parameters. Round count (16) and the shift schedule are fixed by the DES standard.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- key_valid  in  1  a key is offered on key_in/decrypt.
- key_ready  out  1  block is idle and can accept a key.
- key_in  in  64  DES key; key_in[63] = DES bit 1, key_in[0] = DES bit 64.
- decrypt  in  1  sampled with the key; 1 = emit K16 first.
- subkey_valid  out  1  subkey_out holds a valid subkey.
- subkey_ready  in  1  consumer accepts the current subkey.
- subkey_out  out  48  current subkey; [47] = DES bit 1 of Kn.
- round_idx  out  4  sequence position 0..15 of the current subkey (DES round = idx+1 encrypt, 16-idx decrypt).
- last  out  1  high with the 16th subkey of the sequence.
- parity_err  out  1  key byte-parity flag (see Configuration).

## Operation
- State machine IDLE/RUN. Registers: C[27:0], D[27:0], dir, round_idx, state.
- IDLE: key_ready=1, subkey_valid=0. Key accept = key_valid & key_ready.
- On accept:
  - {C,D} = PC-1(key_in). The 8 parity bits are discarded.
  - If decrypt=0, C and D are each rotated left by 1, giving C1/D1. If decrypt=1, C0/D0 are loaded unrotated, since C16=C0.
  - dir<=decrypt, round_idx<=0, state<=RUN.
- RUN:
  - subkey_valid=1.
  - subkey_out = PC-2({C,D}), a combinational function of registered C/D.
  - last = (round_idx==15).
- Subkey handshake = subkey_valid & subkey_ready. On each handshake:
  - round_idx==15: state<=IDLE. C/D are left unchanged.
  - Encrypt, otherwise: rotate C and D left by shift(n+1), where n = round_idx+1.
  - Decrypt, otherwise: rotate C and D right by shift(16-round_idx).
  - In both non-final cases, round_idx<=round_idx+1.
- shift(r) = 1 for r in {1,2,9,16}, 2 otherwise. The total rotation over all rounds is 28.
- Backpressure: while subkey_valid & !subkey_ready, subkey_out, round_idx and last stay stable.
- key_valid during RUN is ignored. key_in is not sampled and no error is raised.
- Reset values: state IDLE, C=D=0, round_idx=0, dir=0, key_ready=1, subkey_valid=0, subkey_out=0, last=0, parity_err=0.
- Reset mid-RUN aborts the sequence. The next cycle is IDLE, no further subkey_valid, and the partial sequence is not resumed.

## Timing
- Key accepted at edge t: subkey_valid is high from t+1 with the first subkey.
- With subkey_ready held high, the 16 subkeys appear on cycles t+1..t+16. key_ready rises at t+17.
- Back-to-back keys therefore cost 17 cycles per key.
- Accept never overlaps the final subkey handshake; a key offered during RUN waits for IDLE.
- No combinational path from key_valid or key_in to any output. subkey_ready affects only state on the next edge, never outputs in the same cycle.

## Configuration
- Macro: DES_KEY_SCHED_PARITY_CHECK_EN.
- Defined:
  - On accept, parity_err<=1 if any key byte (DES bits 1-8, 9-16, …, 57-64) has even parity, else 0.
  - The value holds until the next accept or rst.
  - Subkey generation proceeds regardless of the flag.
- Undefined: parity_err is tied to 0 and no parity logic is built. The port is always present.

## Test plan
- Encrypt: key 0x133457799BBCDFF1, decrypt=0, subkey_ready=1 -> idx0 subkey 0x1B02EFFC7072; idx15 subkey 0xCB3D8B0E17F5 with last=1; key_ready=1 on the cycle after; parity_err=0.
- Decrypt: same key, decrypt=1 -> idx0 subkey 0xCB3D8B0E17F5, idx15 0x1B02EFFC7072; the full sequence equals the encrypt sequence reversed.
- Backpressure: encrypt run with subkey_ready toggled pseudo-randomly, and held low 5 cycles at idx 3 -> subkey_out, round_idx and last stable while stalled; exactly 16 handshakes; values identical to the unstalled run.
- Weak key 0x0101010101010101 -> all 16 subkeys 0x000000000000; parity_err=0. Key 0x0000000000000000 -> subkeys 0; parity_err=1 with the macro, 0 without.
- Key offered during RUN: second key_valid at idx 5 -> ignored, first sequence unaffected. Reset asserted at idx 7 -> subkey_valid=0 and key_ready=1 the following cycle; the next key runs normally from idx 0.
- Back-to-back: two keys queued with key_valid held -> second accepted exactly 17 cycles after the first; no gap or overlap in subkey_valid beyond the single IDLE cycle.

Source files
------------

// File: rtl/des_key_schedule_if.sv
// des_key_schedule_if
//   Handshake bundle between a DES key source / subkey consumer and
//   des_key_schedule.
//   Key side    : key_valid, key_ready, key_in[63:0], decrypt
//   Subkey side : subkey_valid, subkey_ready, subkey_out[47:0],
//                 round_idx[3:0], last, parity_err
//   master : key source / subkey consumer (drives key_*, decrypt, subkey_ready)
//   slave  : the key-schedule block
interface des_key_schedule_if;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
  logic        decrypt;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey_out;
  logic [3:0]  round_idx;
  logic        last;
  logic        parity_err;

  modport master (
    output key_valid, key_in, decrypt, subkey_ready,
    input  key_ready, subkey_valid, subkey_out, round_idx, last, parity_err
  );

  modport slave (
    input  key_valid, key_in, decrypt, subkey_ready,
    output key_ready, subkey_valid, subkey_out, round_idx, last, parity_err
  );
endinterface

// File: rtl/des_key_schedule.sv
// des_key_schedule
//   Iterative DES key schedule. Accepts a 64-bit key and emits the sixteen
//   48-bit round subkeys, one per subkey handshake, in encrypt order
//   (K1..K16) or decrypt order (K16..K1).
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous reset, active-high
//     bus  - des_key_schedule_if.slave (key_valid/key_ready/key_in/decrypt,
//            subkey_valid/subkey_ready/subkey_out/round_idx/last/parity_err)
//   Key bit order: key_in[63] = DES bit 1. subkey_out[47] = DES bit 1 of Kn.
//   Optional feature macro: DES_KEY_SCHED_PARITY_CHECK_EN
//     defined   : parity_err flags any even-parity key byte at key accept
//     undefined : parity_err tied to 0, no parity logic
module des_key_schedule (
  input  logic                 clk,
  input  logic                 rst,
  des_key_schedule_if.slave    bus
);

  typedef enum logic {IDLE, RUN} state_t;

  // PC-1: DES key bit numbers (1..64) feeding C1..C28, D1..D28
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: CD bit numbers (1..56) feeding subkey bits 1..48
  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int unsigned i = 0; i < 56; i++)
      r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int unsigned j = 0; j < 48; j++)
      r[6'(47 - j)] = cd[6'(56 - PC2[j])];
    return r;
  endfunction

  function automatic logic [27:0] rol1(input logic [27:0] x);
    return {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rol2(input logic [27:0] x);
    return {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] ror1(input logic [27:0] x);
    return {x[0], x[27:1]};
  endfunction

  function automatic logic [27:0] ror2(input logic [27:0] x);
    return {x[1:0], x[27:2]};
  endfunction

  // Rounds 1, 2, 9 and 16 rotate by one position; all others by two.
  function automatic logic single_shift(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
  endfunction

  state_t      state;
  logic [27:0] c_q, d_q;
  logic        dir_q;
  logic [3:0]  idx_q;
  logic        key_ready_q;
  logic        valid_q;
  logic        last_q;

  logic [55:0] key_cd;
  logic [4:0]  shift_round;
  logic        shift_one;
  logic [27:0] c_next, d_next;

  always_comb begin
    key_cd = pc1(bus.key_in);
    // Encrypt steps Kn -> Kn+1 with shift(n+1); decrypt undoes the shift
    // that produced the currently held subkey, i.e. shift(16-idx).
    if (dir_q)
      shift_round = 5'd16 - {1'b0, idx_q};
    else
      shift_round = {1'b0, idx_q} + 5'd2;
    shift_one = single_shift(shift_round);
    if (dir_q) begin
      c_next = shift_one ? ror1(c_q) : ror2(c_q);
      d_next = shift_one ? ror1(d_q) : ror2(d_q);
    end else begin
      c_next = shift_one ? rol1(c_q) : rol2(c_q);
      d_next = shift_one ? rol1(d_q) : rol2(d_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      c_q         <= '0;
      d_q         <= '0;
      dir_q       <= 1'b0;
      idx_q       <= '0;
      key_ready_q <= 1'b1;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.key_valid) begin
            // Decrypt starts from C0/D0 unrotated because C16/D16 == C0/D0.
            if (bus.decrypt) begin
              c_q <= key_cd[55:28];
              d_q <= key_cd[27:0];
            end else begin
              c_q <= rol1(key_cd[55:28]);
              d_q <= rol1(key_cd[27:0]);
            end
            dir_q       <= bus.decrypt;
            idx_q       <= '0;
            state       <= RUN;
            key_ready_q <= 1'b0;
            valid_q     <= 1'b1;
            last_q      <= 1'b0;
          end
        end
        RUN: begin
          if (bus.subkey_ready) begin
            if (idx_q == 4'd15) begin
              state       <= IDLE;
              key_ready_q <= 1'b1;
              valid_q     <= 1'b0;
              last_q      <= 1'b0;
            end else begin
              c_q    <= c_next;
              d_q    <= d_next;
              idx_q  <= idx_q + 4'd1;
              last_q <= (idx_q == 4'd14);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.key_ready    = key_ready_q;
  assign bus.subkey_valid = valid_q;
  assign bus.subkey_out   = pc2({c_q, d_q});
  assign bus.round_idx    = idx_q;
  assign bus.last         = last_q;

`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
  logic parity_q;
  logic even_byte;

  always_comb begin
    even_byte = 1'b0;
    for (int unsigned b = 0; b < 8; b++)
      if (!(^bus.key_in[8*b +: 8])) even_byte = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      parity_q <= 1'b0;
    else if (state == IDLE && bus.key_valid)
      parity_q <= even_byte;
  end

  assign bus.parity_err = parity_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
